// File: rtl/combat_health_ctrl.sv
// rtl/combat_health_ctrl.sv - per-player attack sequencer, hit/damage bookkeeping and game-over latch
module combat_health_ctrl #(
  parameter int TICK_DIV      = 1666667,
  parameter int WINDUP_TICKS  = 6,
  parameter int ACTIVE_TICKS  = 4,
  parameter int RECOVER_TICKS = 10,
  parameter int DAMAGE        = 3,
  parameter int MAX_HEALTH    = 31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p1_attack,
  input  logic       p2_attack,
  input  logic       p1_collide,
  input  logic       p2_collide,
  input  logic       round_restart,
  output logic [4:0] health_l,
  output logic [4:0] health_r,
  output logic [1:0] p1_state,
  output logic [1:0] p2_state,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       tick
);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_WINDUP  = 2'b01;
  localparam logic [1:0] S_ACTIVE  = 2'b10;
  localparam logic [1:0] S_RECOVER = 2'b11;

  localparam int            CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [4:0]    W_LAST    = 5'(WINDUP_TICKS - 1);
  localparam logic [4:0]    A_LAST    = 5'(ACTIVE_TICKS - 1);
  localparam logic [4:0]    R_LAST    = 5'(RECOVER_TICKS - 1);
  localparam logic [4:0]    DMG       = 5'(DAMAGE);
  localparam logic [4:0]    HMAX      = 5'(MAX_HEALTH);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0][2:0]   sy_q, sy_d;
  logic [1:0][1:0]   st_q, st_d;
  logic [1:0][4:0]   tmr_q, tmr_d;
  logic [1:0]        hd_q, hd_d;
  logic [4:0]        hl_q, hl_d, hr_q, hr_d;
  logic              go_q, go_d;
  logic [1:0]        win_q, win_d;

  logic              tick_c;
  logic              contact;
  logic [1:0]        btn;
  logic [1:0]        press;
  logic [1:0]        hit;
  logic [1:0][4:0]   last;

  assign tick_c = (cnt_q == TICK_LAST);

  always_comb begin
    cnt_d   = tick_c ? '0 : cnt_q + 1'b1;
    contact = p1_collide | p2_collide;
    btn     = {p2_attack, p1_attack};
    go_d    = go_q;
    win_d   = win_q;
    hl_d    = hl_q;
    hr_d    = hr_q;
    for (int i = 0; i < 2; i++) begin
      // sy[0..1] synchronise, sy[2] holds the previous synchronised level for edge detect
      sy_d[i]  = {sy_q[i][1:0], btn[i]};
      press[i] = sy_q[i][1] & ~sy_q[i][2];
      hit[i]   = (st_q[i] == S_ACTIVE) & contact & ~hd_q[i] & ~go_q;
      st_d[i]  = st_q[i];
      tmr_d[i] = tmr_q[i];
      hd_d[i]  = hd_q[i] | hit[i];
      case (st_q[i])
        S_WINDUP: last[i] = W_LAST;
        S_ACTIVE: last[i] = A_LAST;
        default:  last[i] = R_LAST;
      endcase
      if (go_q) begin
        st_d[i]  = S_IDLE;
        tmr_d[i] = '0;
      end else if (st_q[i] == S_IDLE) begin
        if (press[i]) begin
          st_d[i]  = S_WINDUP;
          tmr_d[i] = '0;
          hd_d[i]  = 1'b0;
        end
      end else if (tick_c) begin
        if (tmr_q[i] == last[i]) begin
          st_d[i]  = st_q[i] + 2'd1;
          tmr_d[i] = '0;
        end else begin
          tmr_d[i] = tmr_q[i] + 5'd1;
        end
      end
    end
    if (hit[1]) hl_d = (hl_q > DMG) ? hl_q - DMG : 5'd0;
    if (hit[0]) hr_d = (hr_q > DMG) ? hr_q - DMG : 5'd0;
    if (!go_q && (hl_q == 5'd0 || hr_q == 5'd0)) begin
      go_d  = 1'b1;
      win_d = {hl_q == 5'd0, hr_q == 5'd0};
    end
    // a new round wipes everything except the free-running tick counter
    if (round_restart) begin
      sy_d  = '0;
      st_d  = '0;
      tmr_d = '0;
      hd_d  = '0;
      hl_d  = HMAX;
      hr_d  = HMAX;
      go_d  = 1'b0;
      win_d = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      sy_q  <= '0;
      st_q  <= '0;
      tmr_q <= '0;
      hd_q  <= '0;
      hl_q  <= HMAX;
      hr_q  <= HMAX;
      go_q  <= 1'b0;
      win_q <= 2'b00;
    end else begin
      cnt_q <= cnt_d;
      sy_q  <= sy_d;
      st_q  <= st_d;
      tmr_q <= tmr_d;
      hd_q  <= hd_d;
      hl_q  <= hl_d;
      hr_q  <= hr_d;
      go_q  <= go_d;
      win_q <= win_d;
    end
  end

  assign health_l  = hl_q;
  assign health_r  = hr_q;
  assign p1_state  = st_q[0];
  assign p2_state  = st_q[1];
  assign game_over = go_q;
  assign winner    = win_q;
  assign tick      = tick_c;

endmodule

// File: tb/tb_combat_health_ctrl.sv
// tb/tb_combat_health_ctrl.sv - directed self-checking bench for combat_health_ctrl
module tb_combat_health_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       p1_attack = 1'b0;
  logic       p2_attack = 1'b0;
  logic       p1_collide = 1'b0;
  logic       p2_collide = 1'b0;
  logic       round_restart = 1'b0;
  logic [4:0] health_l, health_r;
  logic [1:0] p1_state, p2_state;
  logic       game_over;
  logic [1:0] winner;
  logic       tick;

  int nvec = 0;
  int nerr = 0;

  combat_health_ctrl #(
    .TICK_DIV(4), .WINDUP_TICKS(2), .ACTIVE_TICKS(2), .RECOVER_TICKS(2),
    .DAMAGE(3), .MAX_HEALTH(31)
  ) dut (
    .clk(clk), .reset(reset),
    .p1_attack(p1_attack), .p2_attack(p2_attack),
    .p1_collide(p1_collide), .p2_collide(p2_collide),
    .round_restart(round_restart),
    .health_l(health_l), .health_r(health_r),
    .p1_state(p1_state), .p2_state(p2_state),
    .game_over(game_over), .winner(winner), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] st(input int who);
    return (who == 1) ? p1_state : p2_state;
  endfunction

  task automatic wait_state(input int who, input logic [1:0] target, input string tag);
    int n = 0;
    while (st(who) !== target && n < 60) begin
      step();
      n++;
    end
    check(tag, 32'(st(who)), 32'(target));
  endtask

  task automatic phase_len(input int who, input logic [1:0] cur, output int n);
    n = 0;
    while (st(who) === cur && n < 60) begin
      step();
      n++;
    end
  endtask

  task automatic tap(input logic a1, input logic a2);
    p1_attack = a1;
    p2_attack = a2;
    step();
    p1_attack = 1'b0;
    p2_attack = 1'b0;
  endtask

  task automatic restart();
    round_restart = 1'b1;
    step();
    round_restart = 1'b0;
  endtask

  initial begin
    int n;
    int exp_r;

    // 1: reset values and tick cadence
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_health_l", 32'(health_l), 32'd31);
    check("rst_health_r", 32'(health_r), 32'd31);
    check("rst_states", 32'({p1_state, p2_state}), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("tick_%0d", i), 32'(tick), 32'((i % 4) == 3));
    end

    // 2: attack without contact, button held to show no retrigger
    p1_attack = 1'b1;
    step();
    check("press_lat_e", 32'(p1_state), 32'd0);
    step();
    check("press_lat_e1", 32'(p1_state), 32'd0);
    step();
    check("press_lat_e2", 32'(p1_state), 32'd1);
    phase_len(1, 2'b01, n);
    check("windup_len_ok", 32'(n >= 5 && n <= 8), 32'd1);
    check("to_active", 32'(p1_state), 32'd2);
    phase_len(1, 2'b10, n);
    check("active_len", 32'(n), 32'd8);
    check("to_recover", 32'(p1_state), 32'd3);
    phase_len(1, 2'b11, n);
    check("recover_len", 32'(n), 32'd8);
    check("to_idle", 32'(p1_state), 32'd0);
    repeat (6) step();
    check("held_no_retrigger", 32'(p1_state), 32'd0);
    check("nohit_health", 32'({health_l, health_r}), 32'({5'd31, 5'd31}));
    p1_attack = 1'b0;
    repeat (3) step();

    // 3: single hit per attack
    p1_collide = 1'b1;
    tap(1'b1, 1'b0);
    wait_state(1, 2'b10, "hit_wait_active");
    check("hit_before", 32'(health_r), 32'd31);
    step();
    check("hit_after", 32'(health_r), 32'd28);
    wait_state(1, 2'b00, "hit_wait_idle");
    check("hit_once_r", 32'(health_r), 32'd28);
    check("hit_once_l", 32'(health_l), 32'd31);
    p1_collide = 1'b0;

    // 4: simultaneous hits
    restart();
    check("restart_l", 32'(health_l), 32'd31);
    check("restart_r", 32'(health_r), 32'd31);
    p2_collide = 1'b1;
    tap(1'b1, 1'b1);
    wait_state(1, 2'b10, "both_wait_active");
    check("both_p2_active", 32'(p2_state), 32'd2);
    check("both_before", 32'({health_l, health_r}), 32'({5'd31, 5'd31}));
    step();
    check("both_after", 32'({health_l, health_r}), 32'({5'd28, 5'd28}));
    wait_state(1, 2'b00, "both_wait_idle");
    check("both_p2_idle", 32'(p2_state), 32'd0);
    p2_collide = 1'b0;

    // 5: repeated hits down to zero and game over
    restart();
    p1_collide = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tap(1'b1, 1'b0);
      wait_state(1, 2'b10, $sformatf("rep_active_%0d", k));
      step();
      exp_r = 31 - 3 * k;
      if (exp_r < 0) exp_r = 0;
      check($sformatf("rep_health_%0d", k), 32'(health_r), 32'(exp_r));
      if (k < 11) wait_state(1, 2'b00, $sformatf("rep_idle_%0d", k));
    end
    step();
    check("go_flag", 32'(game_over), 32'd1);
    check("go_winner", 32'(winner), 32'd1);
    step();
    check("go_p1_idle", 32'(p1_state), 32'd0);
    check("go_health_l", 32'(health_l), 32'd31);
    tap(1'b0, 1'b1);
    repeat (4) step();
    check("go_p2_ignored", 32'(p2_state), 32'd0);
    check("go_frozen_r", 32'(health_r), 32'd0);
    p1_collide = 1'b0;

    // 6: round restart after game over, then reset mid-attack
    restart();
    check("rr_health", 32'({health_l, health_r}), 32'({5'd31, 5'd31}));
    check("rr_game_over", 32'(game_over), 32'd0);
    check("rr_winner", 32'(winner), 32'd0);
    p1_collide = 1'b1;
    tap(1'b1, 1'b0);
    wait_state(1, 2'b10, "rst_wait_active");
    step();
    check("rst_pre_hit", 32'(health_r), 32'd28);
    reset = 1'b0;
    #1;
    check("rst_async_state", 32'(p1_state), 32'd0);
    check("rst_async_health", 32'(health_r), 32'd31);
    check("rst_async_tick", 32'(tick), 32'd0);
    p1_collide = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("rst_release_idle", 32'(p1_state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
